// File: rtl/nib_alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for the sequential nibble ALU.
package nib_alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDM  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_CLB  = 4'h4;
    localparam logic [3:0] OP_CLC  = 4'h5;
    localparam logic [3:0] OP_IAC  = 4'h6;
    localparam logic [3:0] OP_CMC  = 4'h7;
    localparam logic [3:0] OP_RAL  = 4'h8;
    localparam logic [3:0] OP_RAR  = 4'h9;
    localparam logic [3:0] OP_TCC  = 4'hA;
    localparam logic [3:0] OP_DAC  = 4'hB;
    localparam logic [3:0] OP_STC  = 4'hC;
    localparam logic [3:0] OP_DAA  = 4'hD;
    localparam logic [3:0] OP_MADD = 4'hE;
    localparam logic [3:0] OP_MSUB = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    // Digit counter width; never narrower than one bit.
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nib_alu_seq_digit_unit.sv
// One-digit add/subtract with carry/borrow in and out.
// Decimal correction is compiled in only when NIB_ALU_BCD_EN is defined.
module nib_digit_unit #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic          sub,
    input  logic          dec,
    output logic [DW-1:0] s,
    output logic          cout
);

    logic [DW:0] raw;

    // Bit DW of the raw result is the carry (add) or borrow (sub).
    always_comb begin
        if (sub)
            raw = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
        else
            raw = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    end

`ifdef NIB_ALU_BCD_EN
    always_comb begin
        s    = raw[DW-1:0];
        cout = raw[DW];
        if (dec && DW == 4) begin
            if (sub) begin
                if (raw[DW])
                    s = raw[DW-1:0] + DW'(10);
            end else if (raw > (DW+1)'(9)) begin
                s    = raw[DW-1:0] - DW'(10);
                cout = 1'b1;
            end
        end
    end
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign s          = raw[DW-1:0];
    assign cout       = raw[DW];
`endif

endmodule

// File: rtl/nib_alu_seq.sv
// Sequential nibble ALU owning ACC/CY: 1-cycle single-digit ops, NDIG-cycle serial MADD/MSUB.
// Build option: define NIB_ALU_BCD_EN for decimal per-digit MADD/MSUB (DW==4 only).
module nib_alu_seq
    import nib_alu_pkg::*;
#(
    parameter int DW   = 4,
    parameter int NDIG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op_code,
    input  logic [DW-1:0]      opa,
    input  logic [DW*NDIG-1:0] a_vec,
    input  logic [DW*NDIG-1:0] b_vec,
    output logic               res_valid,
    output logic [DW-1:0]      acc_out,
    output logic               cy_out,
    output logic               zero_out,
    output logic [DW*NDIG-1:0] res_vec
);

    localparam int CW = clog2(NDIG);
    localparam int VW = DW * NDIG;
`ifdef NIB_ALU_BCD_EN
    localparam bit MULTI_DEC = (DW == 4);
`else
    localparam bit MULTI_DEC = 1'b0;
`endif

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [DW-1:0]   acc_reg;
    logic            cy_reg;
    logic            zero_reg;
    logic            res_valid_reg;
    logic [VW-1:0]   res_vec_reg;
    logic [VW-1:0]   a_lat_reg;
    logic [VW-1:0]   b_lat_reg;
    logic            sub_lat_reg;
    logic            chain_reg;

    logic [DW-1:0]   du_a, du_b, du_s;
    logic            du_cin, du_sub, du_dec, du_cout;
    logic [CW-1:0]   dig_idx;
    logic [VW-1:0]   res_next;
    logic [DW-1:0]   acc_next;
    logic            cy_next, zero_upd;
    logic [DW:0]     daa_sum;
    logic            is_multi;

    assign is_multi = (op_code == OP_MADD) || (op_code == OP_MSUB);

    // Digit 0 of a multi-digit op is computed from the live inputs in the accept cycle.
    always_comb begin
        du_a   = acc_reg;
        du_b   = opa;
        du_cin = cy_reg;
        du_sub = 1'b0;
        du_dec = 1'b0;
        if (state_reg == ST_MULTI) begin
            du_a   = a_lat_reg[DW*int'(cnt_reg) +: DW];
            du_b   = b_lat_reg[DW*int'(cnt_reg) +: DW];
            du_cin = chain_reg;
            du_sub = sub_lat_reg;
            du_dec = MULTI_DEC;
        end else begin
            case (op_code)
                OP_SUB: du_sub = 1'b1;
                OP_IAC: begin du_b = DW'(1); du_cin = 1'b0; end
                OP_DAC: begin du_b = DW'(1); du_cin = 1'b0; du_sub = 1'b1; end
                OP_MADD, OP_MSUB: begin
                    du_a   = a_vec[DW-1:0];
                    du_b   = b_vec[DW-1:0];
                    du_sub = (op_code == OP_MSUB);
                    du_dec = MULTI_DEC;
                end
                default: ;
            endcase
        end
    end

    nib_digit_unit #(.DW(DW)) u_digit (
        .a    (du_a),
        .b    (du_b),
        .cin  (du_cin),
        .sub  (du_sub),
        .dec  (du_dec),
        .s    (du_s),
        .cout (du_cout)
    );

    always_comb begin
        dig_idx  = (state_reg == ST_MULTI) ? cnt_reg : '0;
        res_next = res_vec_reg;
        res_next[DW*int'(dig_idx) +: DW] = du_s;
    end

    always_comb begin
        acc_next = acc_reg;
        cy_next  = cy_reg;
        zero_upd = 1'b1;
        daa_sum  = {1'b0, acc_reg} + (DW+1)'(6);
        case (op_code)
            OP_NOP: zero_upd = 1'b0;
            OP_LDM: acc_next = opa;
            OP_ADD, OP_SUB, OP_IAC: begin acc_next = du_s; cy_next = du_cout; end
            OP_CLB: begin acc_next = '0; cy_next = 1'b0; end
            OP_CLC: cy_next = 1'b0;
            OP_CMC: cy_next = ~cy_reg;
            OP_RAL: begin acc_next = {acc_reg[DW-2:0], cy_reg}; cy_next = acc_reg[DW-1]; end
            OP_RAR: begin acc_next = {cy_reg, acc_reg[DW-1:1]}; cy_next = acc_reg[0]; end
            OP_TCC: begin acc_next = {{(DW-1){1'b0}}, cy_reg}; cy_next = 1'b0; end
            OP_DAC: begin acc_next = du_s; cy_next = ~du_cout; end
            OP_STC: cy_next = 1'b1;
            OP_DAA: begin
                if (DW == 4) begin
                    if (acc_reg > DW'(9) || cy_reg) begin
                        acc_next = daa_sum[DW-1:0];
                        if (daa_sum[DW])
                            cy_next = 1'b1;
                    end
                end else begin
                    zero_upd = 1'b0;
                end
            end
            default: zero_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            cy_reg        <= 1'b0;
            zero_reg      <= 1'b1;
            res_valid_reg <= 1'b0;
            res_vec_reg   <= '0;
            a_lat_reg     <= '0;
            b_lat_reg     <= '0;
            sub_lat_reg   <= 1'b0;
            chain_reg     <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (is_multi) begin
                            a_lat_reg   <= a_vec;
                            b_lat_reg   <= b_vec;
                            sub_lat_reg <= (op_code == OP_MSUB);
                            chain_reg   <= du_cout;
                            res_vec_reg <= res_next;
                            cnt_reg     <= CW'(1);
                            state_reg   <= ST_MULTI;
                        end else begin
                            acc_reg       <= acc_next;
                            cy_reg        <= cy_next;
                            res_valid_reg <= 1'b1;
                            if (zero_upd)
                                zero_reg <= (acc_next == '0);
                        end
                    end
                end
                ST_MULTI: begin
                    chain_reg   <= du_cout;
                    res_vec_reg <= res_next;
                    if (cnt_reg == CW'(NDIG-1)) begin
                        cnt_reg       <= '0;
                        state_reg     <= ST_IDLE;
                        cy_reg        <= du_cout;
                        zero_reg      <= (res_next == '0);
                        res_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign op_ready  = (state_reg == ST_IDLE);
    assign res_valid = res_valid_reg;
    assign acc_out   = acc_reg;
    assign cy_out    = cy_reg;
    assign zero_out  = zero_reg;
    assign res_vec   = res_vec_reg;

endmodule
